// File: rtl/rv_imem_encoder.sv
// rv_imem_encoder: packs RV32I instruction field bundles into 32-bit words
// (R/I/S/B/U/J formats chosen by opcode) and streams them into instruction
// memory at consecutive word addresses, one word every two cycles.
module rv_imem_encoder #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        op,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   // count value at which memory is completely filled
   localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t              r_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W:0]     r_count;
   logic                r_full;
   logic                r_err;
   logic                r_ready;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;

   logic                w_legal;
   logic [31:0]         w_word;
   logic [ADDR_W:0]     w_count_inc;

   // Select the instruction format from the opcode and pack the fields
   always_comb begin
      w_legal = 1'b0;
      w_word  = 32'h0000_0000;
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111: begin
            w_legal = 1'b1;
            w_word  = {imm[11:0], rs1, funct3, rd, op};
         end
         7'b0100011: begin
            w_legal = 1'b1;
            w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         end
         7'b0110011: begin
            w_legal = 1'b1;
            w_word  = {funct7, rs2, rs1, funct3, rd, op};
         end
         7'b1100011: begin
            w_legal = 1'b1;
            w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         end
         7'b1101111: begin
            w_legal = 1'b1;
            w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         end
         7'b0110111, 7'b0010111: begin
            w_legal = 1'b1;
            w_word  = {imm[31:12], rd, op};
         end
         default: begin
            w_legal = 1'b0;
            w_word  = 32'h0000_0000;
         end
      endcase
   end

   assign w_count_inc = r_count + CNT_ONE;

   // Accept/write state machine; every output comes straight from a register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= BASE_ADDR;
         r_count <= {(ADDR_W+1){1'b0}};
         r_full  <= 1'b0;
         r_err   <= 1'b0;
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= BASE_ADDR;
         r_wdata <= 32'h0000_0000;
      end else if (clear) begin
         // clear wins over an accept or a write completion this edge
         r_state <= ST_IDLE;
         r_ptr   <= BASE_ADDR;
         r_count <= {(ADDR_W+1){1'b0}};
         r_full  <= 1'b0;
         r_err   <= 1'b0;
         r_ready <= 1'b1;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ready <= !r_full;
               if (in_valid && r_ready) begin
                  if (w_legal) begin
                     r_wdata <= w_word;
                     r_addr  <= r_ptr;
                     r_we    <= 1'b1;
                     r_ready <= 1'b0;
                     r_state <= ST_WRITE;
                  end else begin
                     // illegal opcode: flag it, write nothing, pointer unchanged
                     r_err   <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               r_we    <= 1'b0;
               r_ptr   <= r_ptr + PTR_ONE;
               r_count <= w_count_inc;
               r_full  <= (w_count_inc == CAPACITY);
               r_ready <= (w_count_inc != CAPACITY);
               r_state <= ST_IDLE;
            end
            default: begin
               r_we    <= 1'b0;
               r_ready <= !r_full;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_ready;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign count     = r_count;
   assign full      = r_full;
   assign err       = r_err;

endmodule

// File: tb/tb_rv_imem_encoder.sv
// tb_rv_imem_encoder: three encoder instances (ADDR_W=8/base 0, ADDR_W=2/base 0,
// ADDR_W=8/base 0x10) driven with directed bundles and hand-computed words.
module tb_rv_imem_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        vld  [3];
   logic        rstn [3];
   logic        clr  [3];
   logic [6:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm;

   wire         rdy  [3];
   wire         we   [3];
   wire         fl   [3];
   wire         er   [3];
   wire [7:0]   addr [3];
   wire [31:0]  wd   [3];
   wire [8:0]   cnt  [3];
   wire [1:0]   b_addr;
   wire [2:0]   b_cnt;

   assign addr[1] = {6'd0, b_addr};
   assign cnt[1]  = {6'd0, b_cnt};

   rv_imem_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_a (
      .clk(clk), .rst_n(rstn[0]), .clear(clr[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(f3), .funct7(f7), .imm(imm),
      .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wd[0]), .count(cnt[0]),
      .full(fl[0]), .err(er[0]));

   rv_imem_encoder #(.ADDR_W(2), .BASE_ADDR(2'b00)) u_b (
      .clk(clk), .rst_n(rstn[1]), .clear(clr[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(f3), .funct7(f7), .imm(imm),
      .mem_we(we[1]), .mem_addr(b_addr), .mem_wdata(wd[1]), .count(b_cnt),
      .full(fl[1]), .err(er[1]));

   rv_imem_encoder #(.ADDR_W(8), .BASE_ADDR(8'h10)) u_c (
      .clk(clk), .rst_n(rstn[2]), .clear(clr[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
      .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(f3), .funct7(f7), .imm(imm),
      .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wd[2]), .count(cnt[2]),
      .full(fl[2]), .err(er[2]));

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_fields(input int vi);
      op  = vt[vi].op;
      rd  = vt[vi].rd;
      rs1 = vt[vi].rs1;
      rs2 = vt[vi].rs2;
      f3  = vt[vi].f3;
      f7  = vt[vi].f7;
      imm = vt[vi].imm;
   endtask

   // Called at a negedge: present bundle vi, wait for acceptance, check the write.
   task automatic push(input int k, input int vi, input logic [7:0] ea);
      int n;
      set_fields(vi);
      vld[k] = 1'b1;
      n = 0;
      while (rdy[k] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL push_timeout inst=%0d in_ready never high within %0d cycles", k, n);
         vld[k] = 1'b0;
      end else begin
         @(negedge clk);
         vld[k] = 1'b0;
         chk("push_we", {31'd0, we[k]}, 32'd1);
         chk("push_addr", {24'd0, addr[k]}, {24'd0, ea});
         chk("push_wdata", wd[k], vt[vi].exp);
         @(negedge clk);
         chk("push_we_drop", {31'd0, we[k]}, 32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ea;
      //            op          rd     rs1    rs2    f3      f7           imm            expected
      vt[0]  = '{7'b0010011, 5'd1,  5'd0,  5'd0,  3'd0,   7'd0,        32'd5,         32'h00500093};
      vt[1]  = '{7'b0110011, 5'd3,  5'd1,  5'd2,  3'd0,   7'd0,        32'd0,         32'h002081B3};
      vt[2]  = '{7'b0100011, 5'd0,  5'd1,  5'd2,  3'b010, 7'd0,        32'd8,         32'h0020A423};
      vt[3]  = '{7'b1100011, 5'd0,  5'd0,  5'd0,  3'd0,   7'd0,        32'd8,         32'h00000463};
      vt[4]  = '{7'b1101111, 5'd1,  5'd0,  5'd0,  3'd0,   7'd0,        32'd16,        32'h010000EF};
      vt[5]  = '{7'b0110111, 5'd5,  5'd0,  5'd0,  3'd0,   7'd0,        32'h12345000,  32'h123452B7};
      vt[6]  = '{7'b1100011, 5'd7,  5'd0,  5'd0,  3'd0,   7'h55,       32'h00001FFF,  32'hFE000FE3};
      vt[7]  = '{7'b1101111, 5'd0,  5'd9,  5'd0,  3'd0,   7'd0,        32'h001AB801,  32'h801AB06F};
      vt[8]  = '{7'b0000011, 5'd2,  5'd3,  5'd0,  3'b010, 7'd0,        32'hFFFFFFFC,  32'hFFC1A103};
      vt[9]  = '{7'b0110011, 5'd5,  5'd6,  5'd7,  3'd0,   7'b0100000,  32'hFFFFFFFF,  32'h407302B3};
      vt[10] = '{7'b0100011, 5'd5,  5'd31, 5'd31, 3'd0,   7'd0,        32'hFFFFFFFF,  32'hFFFF8FA3};
      vt[11] = '{7'b0010111, 5'd10, 5'd0,  5'd0,  3'd0,   7'd0,        32'hFFFFF123,  32'hFFFFF517};
      vt[12] = '{7'b1100111, 5'd0,  5'd1,  5'd0,  3'd0,   7'd0,        32'd0,         32'h00008067};

      for (int k = 0; k < 3; k++) begin
         vld[k]  = 1'b0;
         rstn[k] = 1'b0;
         clr[k]  = 1'b0;
      end
      set_fields(0);

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
      chk("rst_we", {31'd0, we[0]}, 32'd0);
      chk("rst_addr", {24'd0, addr[0]}, 32'd0);
      chk("rst_wdata", wd[0], 32'd0);
      chk("rst_count", {23'd0, cnt[0]}, 32'd0);
      chk("rst_full", {31'd0, fl[0]}, 32'd0);
      chk("rst_err", {31'd0, er[0]}, 32'd0);
      chk("rst_addr_base10", {24'd0, addr[2]}, 32'h10);
      for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, rdy[0]}, 32'd1);

      // back-to-back stream with in_valid held high; fields scrambled while not ready
      for (int i = 0; i < NV; i++) begin
         set_fields(i);
         vld[0] = 1'b1;
         chk("stream_ready_hi", {31'd0, rdy[0]}, 32'd1);
         @(negedge clk);
         chk("stream_we", {31'd0, we[0]}, 32'd1);
         chk("stream_addr", {24'd0, addr[0]}, i);
         chk("stream_wdata", wd[0], vt[i].exp);
         chk("stream_ready_lo", {31'd0, rdy[0]}, 32'd0);
         set_fields((i + 7) % NV);
         @(negedge clk);
         chk("stream_we_lo", {31'd0, we[0]}, 32'd0);
         chk("stream_wdata_hold", wd[0], vt[i].exp);
         chk("stream_count", {23'd0, cnt[0]}, i + 1);
      end
      vld[0] = 1'b0;

      // illegal opcode: err sticky, nothing written, pointer unchanged
      set_fields(0);
      op = 7'b0000000;
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      chk("illegal_err", {31'd0, er[0]}, 32'd1);
      chk("illegal_we", {31'd0, we[0]}, 32'd0);
      chk("illegal_count", {23'd0, cnt[0]}, NV);
      chk("illegal_ready", {31'd0, rdy[0]}, 32'd1);
      @(negedge clk);
      chk("illegal_we2", {31'd0, we[0]}, 32'd0);
      push(0, 1, 8'(NV));
      chk("illegal_err_sticky", {31'd0, er[0]}, 32'd1);
      chk("illegal_next_count", {23'd0, cnt[0]}, NV + 1);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      chk("clear_err", {31'd0, er[0]}, 32'd0);
      chk("clear_count", {23'd0, cnt[0]}, 32'd0);
      push(0, 2, 8'h00);

      // clear during WRITE: strobe already out, but pointer/count return to base
      set_fields(3);
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      chk("clrwr_we", {31'd0, we[0]}, 32'd1);
      chk("clrwr_addr", {24'd0, addr[0]}, 32'd1);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      chk("clrwr_we_lo", {31'd0, we[0]}, 32'd0);
      chk("clrwr_count", {23'd0, cnt[0]}, 32'd0);
      push(0, 4, 8'h00);

      // reset in the WRITE cycle aborts the write
      set_fields(5);
      vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      chk("rstwr_we", {31'd0, we[0]}, 32'd1);
      chk("rstwr_addr", {24'd0, addr[0]}, 32'd1);
      rstn[0] = 1'b0;
      @(negedge clk);
      rstn[0] = 1'b1;
      chk("rstwr_we_lo", {31'd0, we[0]}, 32'd0);
      chk("rstwr_count", {23'd0, cnt[0]}, 32'd0);
      chk("rstwr_addr_base", {24'd0, addr[0]}, 32'd0);
      chk("rstwr_ready", {31'd0, rdy[0]}, 32'd0);
      push(0, 6, 8'h00);
      chk("rstwr_count_after", {23'd0, cnt[0]}, 32'd1);

      // fill the 4-word instance
      for (int i = 0; i < 4; i++) begin
         chk("fill_full_lo", {31'd0, fl[1]}, 32'd0);
         push(1, i + 6, 8'(i));
      end
      chk("fill_full", {31'd0, fl[1]}, 32'd1);
      chk("fill_count", {23'd0, cnt[1]}, 32'd4);
      chk("fill_ready", {31'd0, rdy[1]}, 32'd0);
      set_fields(0);
      vld[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("full_no_we", {31'd0, we[1]}, 32'd0);
      end
      vld[1] = 1'b0;
      chk("full_count_hold", {23'd0, cnt[1]}, 32'd4);
      chk("full_err_clean", {31'd0, er[1]}, 32'd0);
      clr[1] = 1'b1;
      @(negedge clk);
      clr[1] = 1'b0;
      chk("fullclr_full", {31'd0, fl[1]}, 32'd0);
      chk("fullclr_count", {23'd0, cnt[1]}, 32'd0);
      chk("fullclr_ready", {31'd0, rdy[1]}, 32'd1);
      push(1, 5, 8'h00);

      // non-zero base: 256 writes wrap from 0xFF to 0x00, then full
      for (int i = 0; i < 256; i++) begin
         ea = 8'h10 + i[7:0];
         push(2, i % NV, ea);
         if (i == 254) begin
            chk("base_full_lo", {31'd0, fl[2]}, 32'd0);
            chk("base_count_255", {23'd0, cnt[2]}, 32'd255);
         end
      end
      chk("base_full", {31'd0, fl[2]}, 32'd1);
      chk("base_count", {23'd0, cnt[2]}, 32'd256);
      chk("base_ready", {31'd0, rdy[2]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
